// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - common data bus: per-source FIFOs, round-robin grant onto registered buses
// Up to NUM_BUS FIFO heads win each cycle in scan order from the RR pointer.
module cdb_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int NUM_BUS    = 2,
  parameter int ROB_W      = 5,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        clear_in,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*ROB_W-1:0]    src_rob_id,
  input  logic [NUM_SRC*DATA_W-1:0]   src_value,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic [NUM_BUS-1:0]          cdb_valid,
  output logic [NUM_BUS*ROB_W-1:0]    cdb_rob_id,
  output logic [NUM_BUS*DATA_W-1:0]   cdb_value
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(NUM_BUS + 1);

  logic [ROB_W-1:0]  r_mem_rob [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0] r_mem_val [NUM_SRC][FIFO_DEPTH];
  logic [AW:0]       r_wptr    [NUM_SRC];
  logic [AW:0]       r_rptr    [NUM_SRC];
  logic [PW-1:0]     r_rr;
  logic [NUM_BUS-1:0] r_cdb_valid;
  logic [ROB_W-1:0]  r_cdb_rob [NUM_BUS];
  logic [DATA_W-1:0] r_cdb_val [NUM_BUS];

  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_full;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_grant;
  logic [ROB_W-1:0]   w_head_rob [NUM_SRC];
  logic [DATA_W-1:0]  w_head_val [NUM_SRC];
  logic [PW-1:0]      w_bus_src  [NUM_BUS];
  logic [CW-1:0]      w_gcnt;
  logic [PW-1:0]      w_last;
  logic [PW-1:0]      w_rr_next;
  logic [PW:0]        w_scan;
  logic [PW-1:0]      w_sidx;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_empty[i]    = (r_wptr[i] == r_rptr[i]);
      w_full[i]     = (r_wptr[i][AW] != r_rptr[i][AW]) &&
                      (r_wptr[i][AW-1:0] == r_rptr[i][AW-1:0]);
      w_head_rob[i] = r_mem_rob[i][r_rptr[i][AW-1:0]];
      w_head_val[i] = r_mem_val[i][r_rptr[i][AW-1:0]];
    end
  end

  // Readiness looks only at registered occupancy: a full FIFO refuses even while popped.
  assign src_ready = {NUM_SRC{rdy_in & ~clear_in}} & ~w_full;
  assign w_push    = src_valid & src_ready;

  always_comb begin
    w_grant = '0;
    w_gcnt  = '0;
    w_last  = r_rr;
    w_scan  = '0;
    w_sidx  = '0;
    for (int b = 0; b < NUM_BUS; b++) w_bus_src[b] = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_scan = {1'b0, r_rr} + (PW+1)'(k);
      if (w_scan >= (PW+1)'(NUM_SRC)) w_scan = w_scan - (PW+1)'(NUM_SRC);
      w_sidx = w_scan[PW-1:0];
      if (!w_empty[w_sidx] && (w_gcnt < CW'(NUM_BUS))) begin
        for (int b = 0; b < NUM_BUS; b++)
          if (w_gcnt == CW'(b)) w_bus_src[b] = w_sidx;
        w_grant[w_sidx] = 1'b1;
        w_last          = w_sidx;
        w_gcnt          = w_gcnt + 1'b1;
      end
    end
    w_rr_next = (w_last == PW'(NUM_SRC - 1)) ? '0 : w_last + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
      r_rr        <= '0;
      r_cdb_valid <= '0;
      for (int b = 0; b < NUM_BUS; b++) begin
        r_cdb_rob[b] <= '0;
        r_cdb_val[b] <= '0;
      end
    end else if (clear_in) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end
      r_rr        <= '0;
      r_cdb_valid <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_push[i])  r_wptr[i] <= r_wptr[i] + 1'b1;
        if (w_grant[i]) r_rptr[i] <= r_rptr[i] + 1'b1;
      end
      if (w_gcnt != '0) r_rr <= w_rr_next;
      for (int b = 0; b < NUM_BUS; b++) begin
        r_cdb_valid[b] <= (CW'(b) < w_gcnt);
        r_cdb_rob[b]   <= w_head_rob[w_bus_src[b]];
        r_cdb_val[b]   <= w_head_val[w_bus_src[b]];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_push[i] && !rst_in) begin
        r_mem_rob[i][r_wptr[i][AW-1:0]] <= src_rob_id[i*ROB_W +: ROB_W];
        r_mem_val[i][r_wptr[i][AW-1:0]] <= src_value[i*DATA_W +: DATA_W];
      end
    end
  end

  assign cdb_valid = r_cdb_valid;

  always_comb begin
    cdb_rob_id = '0;
    cdb_value  = '0;
    for (int b = 0; b < NUM_BUS; b++) begin
      cdb_rob_id[b*ROB_W +: ROB_W]   = r_cdb_rob[b];
      cdb_value[b*DATA_W +: DATA_W]  = r_cdb_val[b];
    end
  end

endmodule
